// File: rtl/pll_lock_supervisor_if.sv
// Status/handshake bundle between the PLL lock supervisor, the PLL and downstream logic.
// Macro PLL_SUP_FORCE_RELOCK_EN adds the force_relock request line.
interface pll_lock_supervisor_if;
   logic       locked;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [2:0] retry_cnt;
   logic [7:0] lock_loss_cnt;
   logic [2:0] state_o;
`ifdef PLL_SUP_FORCE_RELOCK_EN
   logic       force_relock;
`endif

   modport master (
`ifdef PLL_SUP_FORCE_RELOCK_EN
      input  force_relock,
`endif
      input  locked,
      output pll_rst, sys_rst, ready, fail, retry_cnt, lock_loss_cnt, state_o
   );

   modport slave (
`ifdef PLL_SUP_FORCE_RELOCK_EN
      output force_relock,
`endif
      output locked,
      input  pll_rst, sys_rst, ready, fail, retry_cnt, lock_loss_cnt, state_o
   );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor on refclk: pulses the PLL reset, qualifies lock, releases sys_rst, retries/gives up.
// Optional macro PLL_SUP_FORCE_RELOCK_EN enables the force_relock request.
module pll_lock_supervisor #(
   parameter int unsigned RST_CYCLES     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned STABLE_CYCLES  = 1024,
   parameter int unsigned MAX_RETRIES    = 4,
   parameter int unsigned CNT_W          = 17
) (
   input  logic                  refclk,
   input  logic                  rst,
   pll_lock_supervisor_if.master bus
);

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRIES);

   state_t           state;
   logic [CNT_W-1:0] timer;
   logic             locked_m;
   logic             locked_s;
   logic             pll_rst_q;
   logic             sys_rst_q;
   logic             ready_q;
   logic             fail_q;
   logic [2:0]       retry_cnt_q;
   logic [7:0]       lock_loss_q;
   logic [2:0]       retry_inc;

   always_comb begin
      retry_inc = (retry_cnt_q == 3'd7) ? 3'd7 : retry_cnt_q + 3'd1;
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state       <= RESET_PLL;
         timer       <= '0;
         locked_m    <= 1'b0;
         locked_s    <= 1'b0;
         pll_rst_q   <= 1'b1;
         sys_rst_q   <= 1'b1;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
         retry_cnt_q <= '0;
         lock_loss_q <= '0;
      end else begin
         locked_m <= bus.locked;
         locked_s <= locked_m;
         case (state)
            RESET_PLL: begin
               pll_rst_q <= 1'b1;
               sys_rst_q <= 1'b1;
               if (timer == RST_LAST) begin
                  state     <= WAIT_LOCK;
                  timer     <= '0;
                  pll_rst_q <= 1'b0;
               end else begin
                  timer <= timer + CNT_W'(1);
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state <= STABLE;
                  timer <= '0;
               end else if (timer == TIMEOUT_LAST) begin
                  timer       <= '0;
                  retry_cnt_q <= retry_inc;
                  pll_rst_q   <= 1'b1;
                  if (retry_inc == RETRY_LIMIT) begin
                     state  <= FAIL;
                     fail_q <= 1'b1;
                  end else begin
                     state <= RESET_PLL;
                  end
               end else begin
                  timer <= timer + CNT_W'(1);
               end
            end
            STABLE: begin
               // A lock glitch restarts the timeout window without charging a retry.
               if (!locked_s) begin
                  state <= WAIT_LOCK;
                  timer <= '0;
               end else if (timer == STABLE_LAST) begin
                  state       <= RUN;
                  timer       <= '0;
                  sys_rst_q   <= 1'b0;
                  ready_q     <= 1'b1;
                  retry_cnt_q <= '0;
               end else begin
                  timer <= timer + CNT_W'(1);
               end
            end
            RUN: begin
               if (!locked_s) begin
                  state     <= RESET_PLL;
                  timer     <= '0;
                  pll_rst_q <= 1'b1;
                  sys_rst_q <= 1'b1;
                  ready_q   <= 1'b0;
                  if (lock_loss_q != 8'hFF)
                     lock_loss_q <= lock_loss_q + 8'd1;
               end
            end
            FAIL: begin
               pll_rst_q <= 1'b1;
               sys_rst_q <= 1'b1;
               fail_q    <= 1'b1;
            end
            default: begin
               state     <= RESET_PLL;
               timer     <= '0;
               pll_rst_q <= 1'b1;
               sys_rst_q <= 1'b1;
               ready_q   <= 1'b0;
               fail_q    <= 1'b0;
            end
         endcase
`ifdef PLL_SUP_FORCE_RELOCK_EN
         // Overrides the case above; a coincident RUN lock loss still bumps lock_loss_q there.
         if (bus.force_relock && (state != RESET_PLL)) begin
            state       <= RESET_PLL;
            timer       <= '0;
            retry_cnt_q <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
         end
`endif
      end
   end

   assign bus.pll_rst       = pll_rst_q;
   assign bus.sys_rst       = sys_rst_q;
   assign bus.ready         = ready_q;
   assign bus.fail          = fail_q;
   assign bus.retry_cnt     = retry_cnt_q;
   assign bus.lock_loss_cnt = lock_loss_q;
   assign bus.state_o       = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: every state change is checked against a queued expectation
// (state, outputs, and number of cycles spent in the previous state).
module tb_pll_lock_supervisor;

   typedef struct packed {
      logic [2:0]  st;
      logic        pll_rst;
      logic        sys_rst;
      logic        ready;
      logic        fail;
      logic [2:0]  retry;
      logic [7:0]  loss;
      logic [15:0] dwell;
   } snap_t;

   logic  refclk = 1'b0;
   logic  rst;
   snap_t exp_q[$];
   int    errors = 0;
   int    checks = 0;
   bit    mon_en = 1'b0;
   logic [2:0]  prev_st = 3'd0;
   logic [15:0] dwell = '0;

   pll_lock_supervisor_if bus();

   pll_lock_supervisor #(
      .RST_CYCLES(4),
      .TIMEOUT_CYCLES(50),
      .STABLE_CYCLES(8),
      .MAX_RETRIES(3),
      .CNT_W(17)
   ) dut (
      .refclk(refclk),
      .rst(rst),
      .bus(bus)
   );

   always #5 refclk = ~refclk;

   // Expected outputs per state are fixed by the state itself; only counters and dwell vary.
   task automatic expect_change(input logic [2:0] st, input logic [2:0] retry,
                                input logic [7:0] loss, input int dw);
      snap_t e;
      e.st      = st;
      e.pll_rst = (st == 3'd0) || (st == 3'd4);
      e.sys_rst = (st != 3'd3);
      e.ready   = (st == 3'd3);
      e.fail    = (st == 3'd4);
      e.retry   = retry;
      e.loss    = loss;
      e.dwell   = 16'(dw);
      exp_q.push_back(e);
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget);
      int n = 0;
      do begin
         @(posedge refclk);
         #1;
         n++;
      end while ((bus.state_o != s) && (n < budget));
      if (bus.state_o != s) begin
         checks++;
         errors++;
         $display("FAIL wait_state: state_o=%0d required=%0d after %0d cycles", bus.state_o, s, n);
      end
   endtask

   always @(negedge refclk) begin
      if (mon_en) begin
         if (bus.state_o !== prev_st) begin
            snap_t a;
            snap_t e;
            a = '{bus.state_o, bus.pll_rst, bus.sys_rst, bus.ready, bus.fail,
                  bus.retry_cnt, bus.lock_loss_cnt, dwell};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_transition: %0d->%0d with no expectation queued",
                        prev_st, bus.state_o);
            end else begin
               e = exp_q.pop_front();
               if (a !== e) begin
                  errors++;
                  $display("FAIL transition %0d->%0d: got st=%0d pll=%b sys=%b rdy=%b fail=%b retry=%0d loss=%0d dwell=%0d, required st=%0d pll=%b sys=%b rdy=%b fail=%b retry=%0d loss=%0d dwell=%0d",
                           prev_st, bus.state_o,
                           a.st, a.pll_rst, a.sys_rst, a.ready, a.fail, a.retry, a.loss, a.dwell,
                           e.st, e.pll_rst, e.sys_rst, e.ready, e.fail, e.retry, e.loss, e.dwell);
               end
            end
            prev_st = bus.state_o;
            dwell   = 16'd1;
         end else begin
            dwell = dwell + 16'd1;
         end
      end
   end

   initial begin
      repeat (30000) @(posedge refclk);
      errors++;
      $display("FAIL watchdog: simulation still running after 30000 cycles");
      $display("Result: errors=%0d of %0d checks", errors, checks + 1);
      $finish;
   end

   initial begin
      int loss;
      rst        = 1'b1;
      bus.locked = 1'b0;
`ifdef PLL_SUP_FORCE_RELOCK_EN
      bus.force_relock = 1'b0;
`endif
      repeat (3) @(posedge refclk);
      #1;
      checks++;
      if ({bus.state_o, bus.pll_rst, bus.sys_rst, bus.ready, bus.fail, bus.retry_cnt, bus.lock_loss_cnt}
          !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0}) begin
         errors++;
         $display("FAIL reset_values: st=%0d pll=%b sys=%b rdy=%b fail=%b retry=%0d loss=%0d, required 0 1 1 0 0 0 0",
                  bus.state_o, bus.pll_rst, bus.sys_rst, bus.ready, bus.fail, bus.retry_cnt, bus.lock_loss_cnt);
      end
      rst    = 1'b0;
      mon_en = 1'b1;

      // Initial lock: locked rises five cycles after pll_rst falls.
      expect_change(3'd1, 3'd0, 8'd0, 4);
      wait_state(3'd1, 100);
      repeat (5) @(posedge refclk);
      #1 bus.locked = 1'b1;
      expect_change(3'd2, 3'd0, 8'd0, 8);
      expect_change(3'd3, 3'd0, 8'd0, 8);
      wait_state(3'd3, 100);

      // First lock loss, then a one-cycle lock glitch at STABLE timer=5.
      bus.locked = 1'b0;
      expect_change(3'd0, 3'd0, 8'd1, 3);
      expect_change(3'd1, 3'd0, 8'd1, 4);
      wait_state(3'd1, 100);
      bus.locked = 1'b1;
      expect_change(3'd2, 3'd0, 8'd1, 3);
      wait_state(3'd2, 100);
      repeat (3) @(posedge refclk);
      #1 bus.locked = 1'b0;
      @(posedge refclk);
      #1 bus.locked = 1'b1;
      expect_change(3'd1, 3'd0, 8'd1, 6);
      expect_change(3'd2, 3'd0, 8'd1, 1);
      expect_change(3'd3, 3'd0, 8'd1, 8);
      wait_state(3'd3, 100);

      // Repeated lock losses up to 260 in total; the counter saturates at 255.
      for (int i = 2; i <= 260; i++) begin
         loss = (i > 255) ? 255 : i;
         bus.locked = 1'b0;
         expect_change(3'd0, 3'd0, 8'(loss), 3);
         expect_change(3'd1, 3'd0, 8'(loss), 4);
         wait_state(3'd1, 100);
         bus.locked = 1'b1;
         expect_change(3'd2, 3'd0, 8'(loss), 3);
         expect_change(3'd3, 3'd0, 8'(loss), 8);
         wait_state(3'd3, 100);
      end

      // One timeout, then rst while WAIT_LOCK timer=20 clears everything.
      bus.locked = 1'b0;
      expect_change(3'd0, 3'd0, 8'd255, 3);
      expect_change(3'd1, 3'd0, 8'd255, 4);
      wait_state(3'd1, 100);
      expect_change(3'd0, 3'd1, 8'd255, 50);
      expect_change(3'd1, 3'd1, 8'd255, 4);
      wait_state(3'd0, 200);
      wait_state(3'd1, 100);
      repeat (20) @(posedge refclk);
      #1 rst = 1'b1;
      expect_change(3'd0, 3'd0, 8'd0, 21);
      @(posedge refclk);
      #1 rst = 1'b0;

      // Lock never arrives: three PLL reset pulses, then FAIL.
      expect_change(3'd1, 3'd0, 8'd0, 4);
      expect_change(3'd0, 3'd1, 8'd0, 50);
      expect_change(3'd1, 3'd1, 8'd0, 4);
      expect_change(3'd0, 3'd2, 8'd0, 50);
      expect_change(3'd1, 3'd2, 8'd0, 4);
      expect_change(3'd4, 3'd3, 8'd0, 50);
      wait_state(3'd4, 400);
      #1 bus.locked = 1'b1;
      repeat (20) @(posedge refclk);

`ifdef PLL_SUP_FORCE_RELOCK_EN
      // force_relock leaves FAIL and a normal lock follows.
      #1 bus.force_relock = 1'b1;
      expect_change(3'd0, 3'd0, 8'd0, 21);
      @(posedge refclk);
      #1 bus.force_relock = 1'b0;
      expect_change(3'd1, 3'd0, 8'd0, 4);
      expect_change(3'd2, 3'd0, 8'd0, 1);
      expect_change(3'd3, 3'd0, 8'd0, 8);
      wait_state(3'd3, 100);
      bus.locked = 1'b0;
      expect_change(3'd0, 3'd0, 8'd1, 3);
      expect_change(3'd1, 3'd0, 8'd1, 4);
      wait_state(3'd1, 100);
      bus.locked = 1'b1;
      expect_change(3'd2, 3'd0, 8'd1, 3);
      expect_change(3'd3, 3'd0, 8'd1, 8);
      wait_state(3'd3, 100);
      // force_relock in RUN, held a second cycle into RESET_PLL where it is ignored.
      bus.force_relock = 1'b1;
      expect_change(3'd0, 3'd0, 8'd1, 1);
      repeat (2) @(posedge refclk);
      #1 bus.force_relock = 1'b0;
      expect_change(3'd1, 3'd0, 8'd1, 4);
      expect_change(3'd2, 3'd0, 8'd1, 1);
      expect_change(3'd3, 3'd0, 8'd1, 8);
      wait_state(3'd3, 100);
`endif

      repeat (10) @(posedge refclk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_expectations: %0d left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
